// File: rtl/axi_lite_inst_rom_slave.sv
// AXI4-Lite read-only instruction memory responder.
// Serves the fetch unit's AR/R ports from a word-addressed memory that is
// preloaded through a sideband port. Each accepted read is decoded and the
// memory is read in the accept cycle. The result then travels through a
// fixed-latency pipeline into an in-order response queue.
//
// Handshake rules (AR and R channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   s_axi_arready is driven from registered state only (the outstanding
//   credit count), so it never depends on s_axi_arvalid. Once s_axi_rvalid
//   is high it stays high with stable rdata/rresp until s_axi_rready is seen.
module axi_lite_inst_rom_slave #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    PROT_WIDTH   = 3,
  parameter int                    RESP_WIDTH   = 4,
  parameter int                    MEM_DEPTH    = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_0000),
  parameter int                    LATENCY      = 2,
  parameter int                    RESP_Q_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  // read address channel
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [PROT_WIDTH-1:0]        s_axi_arprot,
  // read data channel
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [RESP_WIDTH-1:0]        s_axi_rresp,
  // memory preload port
  input  logic                         load_wen,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_wdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(RESP_Q_DEPTH);
  localparam int CNT_W = $clog2(RESP_Q_DEPTH + 1);

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  // ---------------------------------------------------------------------
  // Instruction memory (no reset; loads are honoured even during reset)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Sideband preload write
  always_ff @(posedge CLK) begin
    if (load_wen) begin
      r_mem[load_addr] <= load_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Credit counter and AR acceptance
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_outstanding;
  logic             w_ar_fire;
  logic             w_q_pop;

  assign s_axi_arready = !RST && (r_outstanding < CNT_W'(RESP_Q_DEPTH));
  assign w_ar_fire     = s_axi_arvalid && s_axi_arready;

  // Count reads that are accepted but not yet returned on R
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ar_fire, w_q_pop})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Address decode and memory read in the accept cycle. The memory read is
  // combinational from the array, so a same-cycle preload to the same word
  // is only seen by later reads.
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_dec_data;
  logic [RESP_WIDTH-1:0] w_dec_resp;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge
  // offsets, which then fall into the out-of-range check.
  assign w_off          = s_axi_araddr - BASE_ADDR;
  assign w_misaligned   = |w_off[1:0];
  assign w_out_of_range = |w_off[ADDR_WIDTH-1:IDX_W+2];
  assign w_idx          = w_off[IDX_W+1:2];

  // Response selection: misalignment wins over range errors
  always_comb begin
    w_dec_data = '0;
    w_dec_resp = RESP_OKAY;
    if (w_misaligned) begin
      w_dec_resp = RESP_SLVERR;
    end else if (w_out_of_range) begin
      w_dec_resp = RESP_DECERR;
    end else begin
      w_dec_data = r_mem[w_idx];
    end
  end

  // Protection bits carry no meaning for an instruction ROM
  logic w_unused_prot;
  assign w_unused_prot = ^s_axi_arprot;

  // ---------------------------------------------------------------------
  // Fixed-latency pipeline feeding the response queue
  // ---------------------------------------------------------------------
  logic                  w_q_wr;
  logic [DATA_WIDTH-1:0] w_q_wdata;
  logic [RESP_WIDTH-1:0] w_q_wresp;

  generate
    if (LATENCY == 1) begin : g_lat1
      // The decode result goes straight into the queue at the accept edge
      assign w_q_wr    = w_ar_fire;
      assign w_q_wdata = w_dec_data;
      assign w_q_wresp = w_dec_resp;
    end else begin : g_pipe
      localparam int NSTG = LATENCY - 1;

      logic [NSTG-1:0]       r_stg_v;
      logic [DATA_WIDTH-1:0] r_stg_d [NSTG];
      logic [RESP_WIDTH-1:0] r_stg_r [NSTG];

      // Shift {valid, data, resp} one stage per cycle
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_stg_v <= '0;
          for (int i = 0; i < NSTG; i++) begin
            r_stg_d[i] <= '0;
            r_stg_r[i] <= '0;
          end
        end else begin
          r_stg_v[0] <= w_ar_fire;
          r_stg_d[0] <= w_dec_data;
          r_stg_r[0] <= w_dec_resp;
          for (int i = 1; i < NSTG; i++) begin
            r_stg_v[i] <= r_stg_v[i-1];
            r_stg_d[i] <= r_stg_d[i-1];
            r_stg_r[i] <= r_stg_r[i-1];
          end
        end
      end

      assign w_q_wr    = r_stg_v[NSTG-1];
      assign w_q_wdata = r_stg_d[NSTG-1];
      assign w_q_wresp = r_stg_r[NSTG-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // In-order response queue. Pointers carry one extra wrap bit so full and
  // empty can be told apart. There is no bypass: an entry written into an
  // empty queue becomes visible on the following cycle.
  // ---------------------------------------------------------------------
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic [DATA_WIDTH-1:0] r_q_data [RESP_Q_DEPTH];
  logic [RESP_WIDTH-1:0] r_q_resp [RESP_Q_DEPTH];
  logic                  w_q_empty;
  logic                  w_q_full;

  assign w_q_empty = (r_wptr == r_rptr);
  assign w_q_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_q_pop   = !w_q_empty && s_axi_rready;

  // Queue pointer update; reset discards every queued response
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_q_wr) begin
        r_wptr <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_q_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // Queue storage write; contents are qualified by the pointers
  always_ff @(posedge CLK) begin
    if (w_q_wr) begin
      r_q_data[r_wptr[PTR_W-1:0]] <= w_q_wdata;
      r_q_resp[r_wptr[PTR_W-1:0]] <= w_q_wresp;
    end
  end

  // R channel is driven from the queue head, zeroed while nothing is valid
  assign s_axi_rvalid = !w_q_empty;
  assign s_axi_rdata  = w_q_empty ? '0 : r_q_data[r_rptr[PTR_W-1:0]];
  assign s_axi_rresp  = w_q_empty ? '0 : r_q_resp[r_rptr[PTR_W-1:0]];

  // ---------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------
  // The credit limit must keep the queue from overflowing
  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(w_q_wr && w_q_full && !w_q_pop));

  // A stalled R beat must hold valid and its payload
  a_r_stable : assert property (@(posedge CLK) disable iff (RST)
    (s_axi_rvalid && !s_axi_rready) |=>
      (s_axi_rvalid && $stable(s_axi_rdata) && $stable(s_axi_rresp)));

  // Never more reads in flight than queue entries
  a_credit_bound : assert property (@(posedge CLK) disable iff (RST)
    r_outstanding <= CNT_W'(RESP_Q_DEPTH));

endmodule
